// File: rtl/imem_loader.sv
// imem_loader: byte stream -> little-endian 32-bit words written to imem; core held in reset until load completes.
// we 1 cycle after 4th byte (4 bytes / 5 cycles); byte_ready low outside RECV/CHK. Trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR_W:0] len,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            we,
  output logic [31:0]     waddr,
  output logic [31:0]     wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            core_rst_n
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;

  state_t          state, state_nxt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] wcnt_inc;
  logic [1:0]      bcnt;
  logic [23:0]     word_q;
  logic            hs;
  logic            start_ok;
  logic            range_err;
  logic            len_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
  logic [7:0]      sum_chk;
  logic            chk_bad;
`endif

  assign hs       = byte_valid && byte_ready;
  assign wcnt_inc = wcnt + (ADDR_W+1)'(1);
  // Only 2**ADDR_W itself is legal once the top bit is set.
  assign len_big  = len[ADDR_W] && (|len[ADDR_W-1:0]);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign sum_chk  = sum + byte_in;
`endif

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    range_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_bad   = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          if (len_big) begin
            range_err = 1'b1;
            state_nxt = IDLE;
          end else if (len == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (hs && bcnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        if (wcnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (hs) begin
          if (sum_chk == 8'h00) begin
            state_nxt = DONE;
          end else begin
            chk_bad   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
      len_q      <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      // Outputs are decoded from the next state so they land registered.
      byte_ready <= (state_nxt == RECV) || (state_nxt == CHK);
      busy       <= (state_nxt == RECV) || (state_nxt == WRITE) || (state_nxt == CHK);
      we         <= (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
      core_rst_n <= (state_nxt == DONE);

      if (start_ok) begin
        err   <= range_err;
        len_q <= len;
        wcnt  <= '0;
        bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum   <= '0;
`endif
      end

      if (state == RECV && hs) begin
        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum  <= sum_chk;
`endif
        case (bcnt)
          2'd0: word_q[7:0]   <= byte_in;
          2'd1: word_q[15:8]  <= byte_in;
          2'd2: word_q[23:16] <= byte_in;
          default: begin
            wdata <= {byte_in, word_q};
            waddr <= BASE_ADDR + (32'(wcnt) << 2);
          end
        endcase
      end

      if (state == WRITE) wcnt <= wcnt_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (chk_bad) err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-written programs and checks writes, status and reset release.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_rst_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  stream[$];
  logic [31:0] we_addr[$];
  logic [31:0] we_data[$];

  imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_addr.push_back(waddr);
      we_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] status();
    return {byte_ready, we, busy, done, err, core_rst_n};
  endfunction

  task automatic do_start(input logic [10:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered just after a rising edge; returns just after the edge of the last handshake.
  task automatic send_stream(input bit toggle);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  hs;
    while (i < stream.size() && guard < 500) begin
      byte_valid = toggle ? ph : 1'b1;
      byte_in    = stream[i];
      ph = ~ph;
      @(negedge clk);
      hs = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    byte_valid = 1'b0;
    check("stream_accepted", i, stream.size());
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic add_checksum();
    logic [7:0] s = 8'h00;
    foreach (stream[k]) s = s + stream[k];
    stream.push_back(8'h00 - s);
  endtask
`endif

  initial begin
    logic [31:0] exp_addr[4];
    logic [31:0] exp_data[4];
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_data = '{32'h000052B7, 32'h00001337, 32'h006283B3, 32'h00732223};

    // Reset held, then idle with no start.
    #12;
    check("reset_status", 32'(status()), 32'h0);
    check("reset_waddr", waddr, 32'h0);
    check("reset_wdata", wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle_status_%0d", c), 32'(status()), 32'h0);
    end

    // Four-word load with byte_valid held high.
    stream = '{8'hB7, 8'h52, 8'h00, 8'h00, 8'h37, 8'h13, 8'h00, 8'h00,
               8'hB3, 8'h83, 8'h62, 8'h00, 8'h23, 8'h22, 8'h73, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_checksum();
`endif
    do_start(11'd4);
    @(negedge clk);
    check("l4_ready_after_start", byte_ready, 1'b1);
    check("l4_busy", busy, 1'b1);
    check("l4_core_rst_held", core_rst_n, 1'b0);
    @(posedge clk); #1;
    send_stream(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("l4_done", done, 1'b1);
    check("l4_core_rst_rel", core_rst_n, 1'b1);
`else
    @(negedge clk);
    check("l4_last_we", we, 1'b1);
    check("l4_done_before", done, 1'b0);
    @(negedge clk);
    check("l4_done", done, 1'b1);
    check("l4_core_rst_rel", core_rst_n, 1'b1);
    check("l4_busy_end", busy, 1'b0);
`endif
    check("l4_we_count", we_addr.size(), 4);
    for (int k = 0; k < 4 && k < we_addr.size(); k++) begin
      check($sformatf("l4_waddr_%0d", k), we_addr[k], exp_addr[k]);
      check($sformatf("l4_wdata_%0d", k), we_data[k], exp_data[k]);
    end

    // One-word load with byte_valid toggling.
    we_addr.delete(); we_data.delete();
    stream = '{8'h37, 8'h13, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_checksum();
`endif
    do_start(11'd1);
    check("l1_done_cleared", done, 1'b0);
    check("l1_core_rst_low", core_rst_n, 1'b0);
    send_stream(1'b1);
    repeat (3) @(negedge clk);
    check("l1_we_count", we_addr.size(), 1);
    if (we_addr.size() > 0) begin
      check("l1_waddr", we_addr[0], 32'h0);
      check("l1_wdata", we_data[0], 32'h00001337);
    end
    check("l1_done", done, 1'b1);

    // Out-of-range length.
    do_start(11'd1025);
    @(negedge clk);
    check("range_err", err, 1'b1);
    check("range_done", done, 1'b0);
    check("range_ready", byte_ready, 1'b0);
    check("range_core_rst", core_rst_n, 1'b0);
    repeat (2) @(negedge clk);
    check("range_status_later", 32'(status()), 32'h02);

    // Empty load.
    do_start(11'd0);
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_err_cleared", err, 1'b0);
    check("len0_core_rst", core_rst_n, 1'b1);

    // Reset mid-load after 6 bytes of a 4-word load.
    we_addr.delete(); we_data.delete();
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start(11'd4);
    send_stream(1'b0);
    rst = 1'b0;
    #1;
    check("midrst_status", 32'(status()), 32'h0);
    check("midrst_waddr", waddr, 32'h0);
    check("midrst_wdata", wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_we_count", we_addr.size(), 1);
    check("midrst_idle", 32'(status()), 32'h0);

    // Fresh one-word load after reset lands at address 0.
    we_addr.delete(); we_data.delete();
    stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_checksum();
`endif
    do_start(11'd1);
    send_stream(1'b0);
    repeat (3) @(negedge clk);
    check("fresh_we_count", we_addr.size(), 1);
    if (we_addr.size() > 0) begin
      check("fresh_waddr", we_addr[0], 32'h0);
      check("fresh_wdata", we_data[0], 32'hDEADBEEF);
    end
    check("fresh_done", done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum pass and fail.
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    do_start(11'd1);
    send_stream(1'b0);
    @(negedge clk);
    check("cks_ok_done", done, 1'b1);
    check("cks_ok_err", err, 1'b0);
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
    do_start(11'd1);
    send_stream(1'b0);
    @(negedge clk);
    check("cks_bad_err", err, 1'b1);
    check("cks_bad_done", done, 1'b0);
    check("cks_bad_core_rst", core_rst_n, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word to sequential word-aligned addresses. It holds the core in reset until a load completes, then releases it so fetch reads the freshly written program.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the target memory (capacity 2**ADDR_W words).
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must be word-aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `len`  in  ADDR_W+1  number of words to load; sampled with `start`.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  stream data valid.
- `byte_ready`  out  1  loader can accept a byte.
- `we`  out  1  single-cycle write strobe to the instruction memory.
- `waddr`  out  32  byte address of the write; the memory indexes it with bits [ADDR_W+1:2].
- `wdata`  out  32  assembled instruction word.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed successfully; sticky until the next accepted `start`.
- `err`  out  1  last start or load failed; sticky until the next accepted `start`.
- `core_rst_n`  out  1  active-low reset to the core.

## Operation
- FSM states:
  - IDLE: reset state. On `start`:
    - `len` > 2**ADDR_W: set `err`, remain IDLE.
    - `len` == 0: go to DONE.
    - Otherwise go to RECV with word counter = 0 and byte counter = 0.
  - RECV: `byte_ready`=1. Each handshake (`byte_valid`&&`byte_ready`) stores `byte_in` into lane [8*k+7:8*k], where k is the byte counter (0..3). The first byte goes to bits [7:0]. When the 4th byte is accepted, go to WRITE.
  - WRITE: one cycle. `we`=1, `waddr`=BASE_ADDR+4*word counter, `byte_ready`=0. Then the word counter increments. If the count equals `len`, go to DONE (or CHK when the macro is enabled); otherwise return to RECV.
  - DONE: `done`=1, `core_rst_n`=1. An accepted `start` re-enters the IDLE decision; a valid start moves to RECV or DONE.
- `busy`=1 in RECV, WRITE and CHK.
- `start` is ignored while `busy`=1.
- An accepted `start` clears `done` and `err` and drives `core_rst_n` to 0 from the next cycle.
- `core_rst_n` is 0 in every state except DONE.
- `wdata` and `waddr` hold their values outside WRITE.
- Address arithmetic is 32-bit and wraps modulo 2**32. The `len` limit guarantees no wrap within the memory index when BASE_ADDR = 0.
- Bytes presented outside RECV are not accepted; `byte_ready`=0.

## Timing
- Reset values: `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, `err`=0, `core_rst_n`=0, state IDLE.
- All outputs are registered.
- `byte_ready` rises the cycle after an accepted `start` with nonzero `len`.
- `we` is asserted the cycle after the 4th byte handshake. Throughput is 4 bytes per 5 cycles with `byte_valid` held high.
- `done` and `core_rst_n` rise the cycle after the final WRITE (or the CHK handshake). With `len`=0 they rise the cycle after `start`.
- Asserting `rst` mid-load returns to reset values immediately. Partial words are discarded and no `we` is issued.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, the FSM enters CHK with `byte_ready`=1 and accepts one extra byte.
  - The load passes if the 8-bit sum of all data bytes plus the checksum byte is 0. It then goes to DONE.
  - On mismatch it sets `err`, leaves `done`=0 and `core_rst_n`=0, and returns to IDLE. Words already written remain in memory.
  - With `len`=0 the checksum stage is skipped.
- `IMEM_LOADER_CHECKSUM_EN` not defined: no CHK state and no trailing byte. `err` reports only the `len` range error.

## Test plan
- Reset then idle: all outputs match reset values and `core_rst_n`=0 for 10 cycles with no `start`.
- `len`=4, stream B7 52 00 00 37 13 00 00 B3 83 62 00 23 22 73 00 with `byte_valid` held high:
  - four `we` pulses at `waddr` 0x0, 0x4, 0x8, 0xC;
  - `wdata` 0x000052B7, 0x00001337, 0x006283B3, 0x00732223;
  - `done`=1 and `core_rst_n`=1 one cycle after the 4th `we`.
- `len`=1 with `byte_valid` toggled every other cycle: exactly one `we` with `wdata`=0x00001337. There is no handshake when `byte_valid`=0.
- Range and empty loads:
  - `len`=1025 with ADDR_W=10: `err`=1, no `byte_ready`, `core_rst_n` stays 0.
  - `len`=0: `done`=1 the next cycle.
- `rst` pulsed low after 6 bytes of a 4-word load: outputs return to reset values immediately and no further `we` is issued. A fresh load of 1 word then writes to address 0x0.
- With `IMEM_LOADER_CHECKSUM_EN` defined, `len`=1, bytes 01 02 03 04:
  - checksum F6 gives `done`=1;
  - checksum F7 gives `err`=1, `done`=0, `core_rst_n`=0.
